// File: rtl/arb_rr_9_5_pkg.sv
// Shared constants, FSM encoding and one-hot helper for the 9-way round-robin arbiter.
package arb_rr_9_5_pkg;

  localparam int N  = 9;
  localparam int W  = 5;
  localparam int SW = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [SW-1:0] SRC_0 = 4'h0;
  localparam logic [SW-1:0] SRC_1 = 4'h1;
  localparam logic [SW-1:0] SRC_2 = 4'h2;
  localparam logic [SW-1:0] SRC_3 = 4'h3;
  localparam logic [SW-1:0] SRC_4 = 4'h4;
  localparam logic [SW-1:0] SRC_5 = 4'h5;
  localparam logic [SW-1:0] SRC_6 = 4'h6;
  localparam logic [SW-1:0] SRC_7 = 4'h7;
  localparam logic [SW-1:0] SRC_8 = 4'h8;

  function automatic logic [N-1:0] src_onehot(input logic [SW-1:0] src);
    return {{(N-1){1'b0}}, 1'b1} << src;
  endfunction

endpackage

// File: rtl/arb_rr_9_5_if.sv
// Requester/consumer bundle: nine request+data pairs in, one valid/ready word out.
interface arb_rr_9_5_if;
  import arb_rr_9_5_pkg::*;

  logic [N-1:0]         req;
  logic [N-1:0][W-1:0]  d;
  logic [N-1:0]         gnt;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic [SW-1:0]        out_src;
  logic                 busy;

  modport master (
    output req, d, out_ready,
    input  gnt, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  req, d, out_ready,
    output gnt, out_valid, out_data, out_src, busy
  );

endinterface

// File: rtl/arb_rr_9_5_mux.sv
// 9-input, 5-bit word selector; out-of-range selects read as zero.
module mux_9_5
  import arb_rr_9_5_pkg::*;
(
  input  logic [SW-1:0]        sel_i,
  input  logic [N-1:0][W-1:0]  data_i,
  output logic [W-1:0]         y_o
);

  // Select one source word
  always_comb begin
    y_o = 5'b00000;
    case (sel_i)
      SRC_0:   y_o = data_i[0];
      SRC_1:   y_o = data_i[1];
      SRC_2:   y_o = data_i[2];
      SRC_3:   y_o = data_i[3];
      SRC_4:   y_o = data_i[4];
      SRC_5:   y_o = data_i[5];
      SRC_6:   y_o = data_i[6];
      SRC_7:   y_o = data_i[7];
      SRC_8:   y_o = data_i[8];
      default: y_o = 5'b00000;
    endcase
  end

endmodule

// File: rtl/arb_rr_9_5.sv
// Round-robin arbiter sharing one 9:1 5-bit selector among nine requesters,
// presenting the chosen word on a registered valid/ready channel.
module arb_rr_9_5
  import arb_rr_9_5_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  arb_rr_9_5_if.slave    arb_io
);

  state_e         state_q, state_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]  out_src_q, out_src_d;

  logic           accept_s;
  logic           arb_en_s;
  logic [N-1:0]   mask_s;
  logic [SW:0]    pick_s;
  logic           found_s;
  logic [SW-1:0]  win_idx_s;
  logic [W-1:0]   mux_y_s;

  // Returns {found, index} of the first set bit at or after ptr, wrapping mod 9.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0] req_v,
                                          input logic [SW-1:0] ptr_v);
    logic [SW:0]   sum;
    logic [SW-1:0] idx;
    logic          found;
    logic [SW-1:0] pick;
    found = 1'b0;
    pick  = SRC_0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_v} + 5'(k);
      if (sum >= 5'd9) begin
        sum = sum - 5'd9;
      end
      idx = sum[SW-1:0];
      if (!found && req_v[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  assign accept_s  = (state_q == ST_GRANT) && arb_io.out_ready;
  assign arb_en_s  = (state_q == ST_IDLE) || accept_s;
  // The word being accepted still has its req high this cycle; keep it out of the race.
  assign mask_s    = accept_s ? src_onehot(out_src_q) : {N{1'b0}};
  assign pick_s    = rr_pick(arb_io.req & ~mask_s, ptr_q);
  assign found_s   = pick_s[SW];
  assign win_idx_s = found_s ? pick_s[SW-1:0] : SRC_0;

  mux_9_5 u_mux (
    .sel_i  (win_idx_s),
    .data_i (arb_io.d),
    .y_o    (mux_y_s)
  );

  // Next-state: latch a new winner whenever the output register is free or being drained
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    if (arb_en_s) begin
      if (found_s) begin
        state_d    = ST_GRANT;
        out_data_d = mux_y_s;
        out_src_d  = win_idx_s;
        ptr_d      = (win_idx_s == SRC_8) ? SRC_0 : (win_idx_s + 4'h1);
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, pointer and output word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= SRC_0;
      out_data_q <= 5'b00000;
      out_src_q  <= SRC_0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  assign arb_io.out_valid = (state_q == ST_GRANT);
  assign arb_io.busy      = (state_q == ST_GRANT);
  assign arb_io.out_data  = out_data_q;
  assign arb_io.out_src   = out_src_q;
  assign arb_io.gnt       = accept_s ? src_onehot(out_src_q) : {N{1'b0}};

endmodule

// File: tb/tb_arb_rr_9_5.sv
// Directed-vector bench for arb_rr_9_5 with hand-computed expectations.
module tb_arb_rr_9_5;
  import arb_rr_9_5_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  arb_rr_9_5_if bus ();

  arb_rr_9_5 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req = 9'h000;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) bus.d[i] = 5'h00;
    tick;
    tick;
    settle;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data",  32'(bus.out_data),  32'h0);
    chk("rst_src",   32'(bus.out_src),   32'h0);
    chk("rst_gnt",   32'(bus.gnt),       32'h0);
    chk("rst_busy",  32'(bus.busy),      32'h0);
    rst_n = 1'b1;
    tick;

    // single request, one-cycle latency
    bus.req = 9'h004;
    bus.d[2] = 5'h15;
    bus.out_ready = 1'b1;
    settle;
    chk("t1_idle_valid", 32'(bus.out_valid), 32'h0);
    chk("t1_idle_gnt",   32'(bus.gnt),       32'h0);
    tick;
    settle;
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_data",  32'(bus.out_data),  32'h15);
    chk("t1_src",   32'(bus.out_src),   32'h2);
    chk("t1_gnt",   32'(bus.gnt),       32'h004);
    chk("t1_busy",  32'(bus.busy),      32'h1);
    tick;
    bus.req = 9'h000;
    settle;
    chk("t1_after_valid", 32'(bus.out_valid), 32'h0);
    chk("t1_after_gnt",   32'(bus.gnt),       32'h0);

    // full rotation with everyone requesting
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) bus.d[i] = 5'(i + 10);
    bus.req = 9'h1FF;
    bus.out_ready = 1'b1;
    tick;
    for (int k = 0; k < 10; k++) begin
      settle;
      chk("t2_valid", 32'(bus.out_valid), 32'h1);
      chk("t2_src",   32'(bus.out_src),   32'(k % 9));
      chk("t2_data",  32'(bus.out_data),  32'((k % 9) + 10));
      chk("t2_gnt",   32'(bus.gnt),       32'(9'h001 << (k % 9)));
      tick;
    end
    bus.req = 9'h000;
    settle;
    chk("t2_src_pending", 32'(bus.out_src), 32'h1);
    tick;
    settle;
    chk("t2_idle", 32'(bus.out_valid), 32'h0);

    // pointer at 8 after granting 7, then wrap to 0
    bus.req = 9'h080;
    tick;
    settle;
    chk("t3_src7", 32'(bus.out_src), 32'h7);
    bus.req = 9'h101;
    settle;
    chk("t3_gnt7", 32'(bus.gnt), 32'h080);
    tick;
    settle;
    chk("t3_src8", 32'(bus.out_src), 32'h8);
    chk("t3_gnt8", 32'(bus.gnt),     32'h100);
    chk("t3_data8", 32'(bus.out_data), 32'd18);
    tick;
    settle;
    chk("t3_src0", 32'(bus.out_src),  32'h0);
    chk("t3_gnt0", 32'(bus.gnt),      32'h001);
    chk("t3_data0", 32'(bus.out_data), 32'd10);
    bus.req = 9'h000;
    tick;
    settle;
    chk("t3_idle", 32'(bus.out_valid), 32'h0);

    // backpressure: word and source held, no grant until ready rises
    bus.req = 9'h008;
    bus.d[3] = 5'h0A;
    bus.out_ready = 1'b0;
    tick;
    settle;
    chk("t4_src", 32'(bus.out_src), 32'h3);
    bus.d[3] = 5'h1F;
    for (int c = 0; c < 5; c++) begin
      settle;
      chk("t4_hold_data",  32'(bus.out_data),  32'h0A);
      chk("t4_hold_gnt",   32'(bus.gnt),       32'h0);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'h1);
      tick;
    end
    bus.out_ready = 1'b1;
    settle;
    chk("t4_acc_gnt",  32'(bus.gnt),      32'h008);
    chk("t4_acc_data", 32'(bus.out_data), 32'h0A);
    tick;
    bus.req = 9'h000;
    settle;
    chk("t4_idle", 32'(bus.out_valid), 32'h0);

    // asynchronous reset mid-GRANT
    bus.req = 9'h020;
    bus.d[5] = 5'h11;
    bus.out_ready = 1'b0;
    tick;
    settle;
    chk("t5_valid", 32'(bus.out_valid), 32'h1);
    chk("t5_src",   32'(bus.out_src),   32'h5);
    chk("t5_data",  32'(bus.out_data),  32'h11);
    bus.out_ready = 1'b1;
    settle;
    chk("t5_gnt", 32'(bus.gnt), 32'h020);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("t5_rst_gnt",   32'(bus.gnt),       32'h0);
    chk("t5_rst_data",  32'(bus.out_data),  32'h0);
    chk("t5_rst_src",   32'(bus.out_src),   32'h0);
    chk("t5_rst_busy",  32'(bus.busy),      32'h0);
    rst_n = 1'b1;
    bus.req = 9'h021;
    tick;
    settle;
    chk("t5_restart_src",  32'(bus.out_src),  32'h0);
    chk("t5_restart_data", 32'(bus.out_data), 32'd10);
    bus.req = 9'h000;
    tick;
    settle;
    chk("t5_idle", 32'(bus.out_valid), 32'h0);

    // single requester held: word every other cycle
    bus.req = 9'h010;
    bus.d[4] = 5'h07;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      settle;
      chk("t6_valid", 32'(bus.out_valid), (c % 2 == 0) ? 32'h1 : 32'h0);
      chk("t6_gnt",   32'(bus.gnt),       (c % 2 == 0) ? 32'h010 : 32'h0);
      if (c % 2 == 0) begin
        chk("t6_data", 32'(bus.out_data), 32'h07);
      end
    end
    bus.req = 9'h000;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
